seg_display_mux: RTL and testbench
==================================

// Module: seg_display_mux
// PURPOSE
//   Time-multiplexed driver for an N-digit common-anode 7-segment display. Decodes
//   4-bit hex per digit (0-F), scans one digit per slot with configurable dead time,
//   and snapshots all inputs once per frame so a frame never mixes old and new data.
//   Sits between the counter/BCD logic and the board display pins.
// PARAMETERS
//   NUM_DIGITS   4      digits scanned, 1..8
//   REFRESH_DIV  50000  clocks per digit slot, >= 2
//   DEAD_CYCLES  16     clocks at slot start with all anodes off (anti-ghost), < REFRESH_DIV
// PORTS
//   clkIn       in   1              single clock
//   rstIn       in   1              reset, asynchronous, active-high
//   enIn        in   1              1 = scan/display, 0 = display dark, scan frozen
//   digitsIn    in   4*NUM_DIGITS   hex nibble per digit; digit i = [4i+3:4i], digit 0 rightmost
//   dpIn        in   NUM_DIGITS     decimal point request per digit, 1 = lit
//   blankIn     in   NUM_DIGITS     1 = force digit i blank (segments and dp off)
//   anodeOut    out  NUM_DIGITS     active-low digit select, at most one bit low
//   segOut      out  7              active-low segments, bit0 = A ... bit6 = G
//   decimalOut  out  1              active-low decimal point
//   frameOut    out  1              one-clock pulse when a new snapshot is taken
// BEHAVIOUR
//   - Reset (async, immediate, also mid-scan): slot counter cnt=0, digit index idx=0,
//     snapshot digits=0, dp=0, blank=all 1; anodeOut=all 1, segOut=7'h7F,
//     decimalOut=1, frameOut=0.
//   - enIn=1: cnt counts 0..REFRESH_DIV-1; at REFRESH_DIV-1 cnt->0 and idx->idx+1,
//     idx wraps NUM_DIGITS-1 -> 0. enIn=0: cnt/idx hold, outputs forced dark
//     (anodes all 1, seg 7'h7F, dp 1) on the next clock; re-enable resumes same slot.
//   - Snapshot: on the edge where cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1 (enIn=1),
//     digitsIn/dpIn/blankIn are captured and frameOut=1 for exactly that next cycle.
//     Input changes at any other time are invisible until the next frame.
//   - Outputs are registered from (cnt, idx, snapshot): latency 1 clock. Anode idx low
//     iff cnt >= DEAD_CYCLES; during dead time anodes all 1 but segOut/decimalOut
//     already carry digit idx. Blanked digit: segOut=7'h7F, decimalOut=1, anode still low.
//   - Decode (active low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10
//     A:08 b:03 C:46 d:21 E:06 F:0E. decimalOut = ~dp[idx] unless blanked.
//   - Frame period = NUM_DIGITS*REFRESH_DIV clocks. First frame after reset is dark
//     (snapshot blank); live data appears from the first snapshot on.
//   - Counter widths sized with $clog2; no overflow possible in the legal range.
// CONFIGURATION
//   SEG_MUX_LZB_EN defined: leading-zero blanking on the snapshot. Scanning from digit
//     NUM_DIGITS-1 downward, a digit is blanked while it and all more-significant
//     digits are 0 with dp clear; digit 0 is never zero-suppressed. Computed at
//     snapshot time (registered), no added output latency.
//   Not defined: zeros always displayed; only blankIn blanks digits.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1)
//   1 Reset asserted mid-slot -> same cycle anodeOut=4'hF, segOut=7'h7F, decimalOut=1,
//     frameOut=0; after release first 16 clocks stay dark, frameOut pulses at clock 16.
//   2 digitsIn=16'h1234, dpIn=0 -> after snapshot, slot 0: 1 dark clock then
//     anodeOut=4'b1110 for 3 clocks, segOut=7'h19; slots 1..3 show 30,24,79 in order.
//   3 Change digitsIn to 16'hABCD mid-frame -> display unchanged until next frameOut;
//     then 21,46,03,08 on digits 0..3; frameOut every 16 clocks exactly.
//   4 dpIn=4'b0100, blankIn=4'b0001 -> digit 2 decimalOut=0; digit 0 anode low with
//     segOut=7'h7F, decimalOut=1.
//   5 enIn low for 10 clocks mid-slot -> next clock all dark, cnt/idx frozen; on
//     re-enable same digit resumes with remaining slot length, frame period +10.
//   6 digitsIn=16'h0050: with SEG_MUX_LZB_EN digits 3,2 blank, digit1=12, digit0=40;
//     without it digits 3,2 show 40; with dpIn=4'b1000 digit 3 shows 40 + dp.

Source files
------------

// File: rtl/seg_display_mux.sv
// seg_display_mux: time-multiplexed common-anode 7-segment driver with per-frame input snapshot.
// Define SEG_MUX_LZB_EN to enable leading-zero blanking of the snapshot.
module seg_display_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 16
) (
   input  logic                    clkIn,
   input  logic                    rstIn,
   input  logic                    enIn,
   input  logic [4*NUM_DIGITS-1:0] digitsIn,
   input  logic [NUM_DIGITS-1:0]   dpIn,
   input  logic [NUM_DIGITS-1:0]   blankIn,
   output logic [NUM_DIGITS-1:0]   anodeOut,
   output logic [6:0]              segOut,
   output logic                    decimalOut,
   output logic                    frameOut
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // Scan position
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idxNext;

   // Frame snapshot
   logic [4*NUM_DIGITS-1:0] snapDigits;
   logic [NUM_DIGITS-1:0]   snapDp;
   logic [NUM_DIGITS-1:0]   snapBlank;
   logic [NUM_DIGITS-1:0]   lzMask;
   logic                    takeSnap;

   // Current-slot view of the snapshot
   logic [3:0]            curHex;
   logic                  curDp;
   logic                  curBlank;
   logic [NUM_DIGITS-1:0] anodeSel;

   // Next output values
   logic [NUM_DIGITS-1:0] anodeNext;
   logic [6:0]            segNext;
   logic                  dpNext;

   function automatic logic [6:0] hexToSeg(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   // Next-state logic: slot counter and digit index advance only while enabled
   always_comb begin
      cntNext  = cnt;
      idxNext  = idx;
      takeSnap = 1'b0;
      if (enIn) begin
         if (cnt == CNT_LAST) begin
            cntNext = '0;
            if (idx == IDX_LAST) begin
               idxNext  = '0;
               takeSnap = 1'b1;
            end else begin
               idxNext = idx + 1'b1;
            end
         end else begin
            cntNext = cnt + 1'b1;
         end
      end
   end

`ifdef SEG_MUX_LZB_EN
   logic zeroRun;

   // A digit is suppressed while it and everything above it is a bare zero.
   always_comb begin
      lzMask  = '0;
      zeroRun = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zeroRun   = zeroRun & (digitsIn[4*i +: 4] == 4'h0) & ~dpIn[i];
         lzMask[i] = zeroRun;
      end
   end
`else
   assign lzMask = '0;
`endif

   always_comb begin
      curHex   = 4'h0;
      curDp    = 1'b0;
      curBlank = 1'b1;
      anodeSel = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            curHex      = snapDigits[4*i +: 4];
            curDp       = snapDp[i];
            curBlank    = snapBlank[i];
            anodeSel[i] = 1'b0;
         end
      end
   end

   // Output logic: segments lead the anode through the dead time
   always_comb begin
      anodeNext = '1;
      segNext   = 7'h7F;
      dpNext    = 1'b1;
      if (enIn) begin
         if (cnt >= CNT_DEAD) begin
            anodeNext = anodeSel;
         end
         if (!curBlank) begin
            segNext = hexToSeg(curHex);
            dpNext  = ~curDp;
         end
      end
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         cnt        <= '0;
         idx        <= '0;
         snapDigits <= '0;
         snapDp     <= '0;
         snapBlank  <= '1;
         anodeOut   <= '1;
         segOut     <= 7'h7F;
         decimalOut <= 1'b1;
         frameOut   <= 1'b0;
      end else begin
         cnt        <= cntNext;
         idx        <= idxNext;
         anodeOut   <= anodeNext;
         segOut     <= segNext;
         decimalOut <= dpNext;
         frameOut   <= takeSnap;
         if (takeSnap) begin
            snapDigits <= digitsIn;
            snapDp     <= dpIn;
            snapBlank  <= blankIn | lzMask;
         end
      end
   end

endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: table-driven scoreboard bench for seg_display_mux (4 digits, 4-clock slots, 1 dead clock).
module tb_seg_display_mux;

   localparam int ND    = 4;
   localparam int RD    = 4;
   localparam int DC    = 1;
   localparam int FRAME = ND * RD;
   localparam int NVEC  = 9;

   logic        clkIn = 1'b0;
   logic        rstIn;
   logic        enIn;
   logic [15:0] digitsIn;
   logic [3:0]  dpIn;
   logic [3:0]  blankIn;
   logic [3:0]  anodeOut;
   logic [6:0]  segOut;
   logic        decimalOut;
   logic        frameOut;

   seg_display_mux #(
      .NUM_DIGITS (ND),
      .REFRESH_DIV(RD),
      .DEAD_CYCLES(DC)
   ) dut (
      .clkIn     (clkIn),
      .rstIn     (rstIn),
      .enIn      (enIn),
      .digitsIn  (digitsIn),
      .dpIn      (dpIn),
      .blankIn   (blankIn),
      .anodeOut  (anodeOut),
      .segOut    (segOut),
      .decimalOut(decimalOut),
      .frameOut  (frameOut)
   );

   always #5 clkIn = ~clkIn;

   typedef struct {
      logic [15:0]     digits;
      logic [3:0]      dp;
      logic [3:0]      blank;
      logic [3:0][6:0] seg;
      logic [3:0]      dec;
   } vec_t;

   typedef struct {
      logic [6:0] seg;
      logic       dec;
   } exp_t;

   vec_t vecs[NVEC];
   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clkIn);
      #1;
   endtask

   task automatic driveVec(input vec_t v);
      exp_t e;
      digitsIn = v.digits;
      dpIn     = v.dp;
      blankIn  = v.blank;
      for (int d = 0; d < ND; d++) begin
         e.seg = v.seg[d];
         e.dec = v.dec[d];
         expQ.push_back(e);
      end
   endtask

   task automatic pushExp(input vec_t v);
      exp_t e;
      for (int d = 0; d < ND; d++) begin
         e.seg = v.seg[d];
         e.dec = v.dec[d];
         expQ.push_back(e);
      end
   endtask

   task automatic waitFrame(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!frameOut && n < 64);
      if (!frameOut) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout actual=0 required=1 after %0d clocks", n);
      end
   endtask

   // Walks one full frame starting just after a frameOut pulse.
   task automatic checkFrame(input bit midChange, input logic [15:0] newDigits);
      exp_t       e;
      logic [3:0] an;
      for (int s = 0; s < ND; s++) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1 entries at slot %0d", s);
            return;
         end
         e  = expQ.pop_front();
         an = 4'b0001 << s;
         an = ~an;
         for (int c = 0; c < RD; c++) begin
            tick();
            if (midChange && s == 1 && c == 1) digitsIn = newDigits;
            check(c < DC ? "anode_dead" : "anode_on", anodeOut, c < DC ? 4'hF : an);
            check("seg", segOut, e.seg);
            check("dp", decimalOut, e.dec);
            check("frame_pulse", frameOut, (s == ND - 1 && c == RD - 1) ? 1 : 0);
         end
      end
   endtask

   task automatic firstFrameDark();
      for (int k = 1; k <= FRAME; k++) begin
         tick();
         check("first_frame_seg", segOut, 7'h7F);
         check("first_frame_dp", decimalOut, 1'b1);
         check("first_frame_pulse", frameOut, k == FRAME ? 1 : 0);
      end
   endtask

   initial begin
      int n;

      vecs[0] = '{16'h1234, 4'h0, 4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
      vecs[1] = '{16'hABCD, 4'h0, 4'h0, {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF};
      vecs[2] = '{16'h1234, 4'b0100, 4'b0001, {7'h79, 7'h24, 7'h30, 7'h7F}, 4'b1011};
      vecs[4] = '{16'h0050, 4'b1000, 4'h0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b0111};
      vecs[5] = '{16'h89EF, 4'hF, 4'h0, {7'h00, 7'h10, 7'h06, 7'h0E}, 4'h0};
      vecs[8] = '{16'h5678, 4'hF, 4'b1010, {7'h7F, 7'h02, 7'h7F, 7'h00}, 4'b1010};
`ifdef SEG_MUX_LZB_EN
      vecs[3] = '{16'h0050, 4'h0, 4'h0, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
      vecs[6] = '{16'h0567, 4'h0, 4'h0, {7'h7F, 7'h12, 7'h02, 7'h78}, 4'hF};
      vecs[7] = '{16'h0000, 4'h0, 4'h0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
`else
      vecs[3] = '{16'h0050, 4'h0, 4'h0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF};
      vecs[6] = '{16'h0567, 4'h0, 4'h0, {7'h40, 7'h12, 7'h02, 7'h78}, 4'hF};
      vecs[7] = '{16'h0000, 4'h0, 4'h0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF};
`endif

      rstIn    = 1'b1;
      enIn     = 1'b1;
      digitsIn = 16'h0;
      dpIn     = 4'h0;
      blankIn  = 4'h0;
      repeat (2) tick();
      check("reset_anode", anodeOut, 4'hF);
      check("reset_seg", segOut, 7'h7F);
      check("reset_dp", decimalOut, 1'b1);
      check("reset_frame", frameOut, 1'b0);
      @(negedge clkIn) rstIn = 1'b0;
      firstFrameDark();

      // Table: each vector is snapshotted at the next pulse, then verified for a full frame
      for (int v = 0; v < NVEC; v++) begin
         driveVec(vecs[v]);
         waitFrame(n);
         check("frame_period", n, FRAME);
         checkFrame(1'b0, 16'h0);
      end

      // Mid-frame input change stays invisible until the next snapshot
      driveVec(vecs[0]);
      waitFrame(n);
      checkFrame(1'b0, 16'h0);
      pushExp(vecs[0]);
      checkFrame(1'b1, 16'hABCD);
      pushExp(vecs[1]);
      checkFrame(1'b0, 16'h0);

      // Enable low mid-slot on digit 1: dark, frozen, then resume the same slot
      repeat (6) tick();
      enIn = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("dis_anode", anodeOut, 4'hF);
         check("dis_seg", segOut, 7'h7F);
         check("dis_dp", decimalOut, 1'b1);
         check("dis_frame", frameOut, 1'b0);
      end
      enIn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("resume_anode", anodeOut, 4'b1101);
         check("resume_seg", segOut, 7'h46);
      end
      tick();
      check("resume_next_dead", anodeOut, 4'hF);
      check("resume_next_seg", segOut, 7'h03);
      waitFrame(n);
      check("stretched_period", n + 19, FRAME + 10);

      // Asynchronous reset while a digit is lit
      repeat (6) tick();
      check("pre_reset_anode", anodeOut, 4'b1101);
      #2;
      rstIn = 1'b1;
      #1;
      check("async_reset_anode", anodeOut, 4'hF);
      check("async_reset_seg", segOut, 7'h7F);
      check("async_reset_dp", decimalOut, 1'b1);
      check("async_reset_frame", frameOut, 1'b0);
      tick();
      @(negedge clkIn) rstIn = 1'b0;
      firstFrameDark();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
